ssim_num_den: RTL and testbench

//   Consumes per-lane local statistics (mu_x, mu_y, sigma_x^2, sigma_y^2, sigma_xy)
//   and produces the SSIM numerator and denominator per pixel lane:
//     NUM = (2*mu_x*mu_y + C1) * max(2*sigma_xy + C2, 0)
//     DEN = (mu_x^2 + mu_y^2 + C1) * (sigma_x^2 + sigma_y^2 + C2)

---
 rtl/ssim_pkg.sv | 19 +
 rtl/ssim_lane.sv | 70 +++++++
 rtl/ssim_num_den.sv | 76 +++++++
 tb/tb_ssim_num_den.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssim_pkg.sv
// Shared constants and helpers for the SSIM numerator/denominator stage.
package ssim_pkg;

  // Stabilising constants: round((0.01*255)^2) and round((0.03*255)^2)
  localparam int unsigned C1 = 7;
  localparam int unsigned C2 = 59;

  // Per-lane field widths
  localparam int unsigned MU_W   = 8;
  localparam int unsigned SIG_W  = 16;
  localparam int unsigned TERM_W = 18;
  localparam int unsigned PROD_W = 36;

  // Output beats in one square frame
  function automatic int unsigned beats(input int unsigned image_dim, input int unsigned ppb);
    return (image_dim * image_dim) / ppb;
  endfunction

endpackage

// File: rtl/ssim_lane.sv
// One pixel lane of the SSIM numerator/denominator datapath: terms, products, output regs.
module ssim_lane
  import ssim_pkg::*;
#(
  parameter int unsigned C1 = ssim_pkg::C1,
  parameter int unsigned C2 = ssim_pkg::C2
) (
  input  logic              clk_i,
  input  logic              areset_i,
  input  logic              stall_i,
  input  logic [MU_W-1:0]   mu_x_i,
  input  logic [MU_W-1:0]   mu_y_i,
  input  logic [SIG_W-1:0]  sig_x2_i,
  input  logic [SIG_W-1:0]  sig_y2_i,
  input  logic [SIG_W-1:0]  sig_xy_i,
  output logic [PROD_W-1:0] num_o,
  output logic [PROD_W-1:0] den_o
);

  logic [TERM_W-1:0] a_d, a_q;
  logic [TERM_W-2:0] b_d, b_q;
  logic [TERM_W-1:0] b_raw;
  logic [TERM_W-1:0] e_d, e_q;
  logic [TERM_W-1:0] f_d, f_q;
  logic [PROD_W-1:0] num_d, num_q, den_d, den_q;
  logic [PROD_W-1:0] num_out_q, den_out_q;

  // S1 term formation; sig_xy is two's complement, so 2*sig_xy is sign-extended before C2 is added
  always_comb begin
    a_d   = ((TERM_W'(mu_x_i) * TERM_W'(mu_y_i)) << 1) + TERM_W'(C1);
    b_raw = {sig_xy_i[SIG_W-1], sig_xy_i, 1'b0} + TERM_W'(C2);
    b_d   = b_raw[TERM_W-1] ? '0 : b_raw[TERM_W-2:0];
    e_d   = TERM_W'(mu_x_i) * TERM_W'(mu_x_i) + TERM_W'(mu_y_i) * TERM_W'(mu_y_i)
          + TERM_W'(C1);
    f_d   = TERM_W'(sig_x2_i) + TERM_W'(sig_y2_i) + TERM_W'(C2);
  end

  // S2 products, sized so the worst case cannot wrap
  always_comb begin
    num_d = PROD_W'(a_q) * PROD_W'(b_q);
    den_d = PROD_W'(e_q) * PROD_W'(f_q);
  end

  // Three pipeline stages; data loads every non-stalled cycle, valid is tracked by the top
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      a_q       <= '0;
      b_q       <= '0;
      e_q       <= '0;
      f_q       <= '0;
      num_q     <= '0;
      den_q     <= '0;
      num_out_q <= '0;
      den_out_q <= '0;
    end else if (!stall_i) begin
      a_q       <= a_d;
      b_q       <= b_d;
      e_q       <= e_d;
      f_q       <= f_d;
      num_q     <= num_d;
      den_q     <= den_d;
      num_out_q <= num_q;
      den_out_q <= den_q;
    end
  end

  assign num_o = num_out_q;
  assign den_o = den_out_q;

endmodule

// File: rtl/ssim_num_den.sv
// SSIM numerator/denominator stage: per-lane datapaths plus valid pipe and frame counter.
module ssim_num_den
  import ssim_pkg::*;
#(
  parameter int unsigned PIXELS_PER_BEAT = 16,
  parameter int unsigned IMAGE_DIM       = 512,
  parameter int unsigned C1              = ssim_pkg::C1,
  parameter int unsigned C2              = ssim_pkg::C2
) (
  input  logic                              clk,
  input  logic                              areset,
  input  logic                              stall,
  input  logic                              in_valid,
  input  logic [MU_W*PIXELS_PER_BEAT-1:0]   in_mu_x,
  input  logic [MU_W*PIXELS_PER_BEAT-1:0]   in_mu_y,
  input  logic [SIG_W*PIXELS_PER_BEAT-1:0]  in_sig_x2,
  input  logic [SIG_W*PIXELS_PER_BEAT-1:0]  in_sig_y2,
  input  logic [SIG_W*PIXELS_PER_BEAT-1:0]  in_sig_xy,
  output logic [PROD_W*PIXELS_PER_BEAT-1:0] out_num,
  output logic [PROD_W*PIXELS_PER_BEAT-1:0] out_den,
  output logic                              out_valid,
  output logic                              out_last
);

  localparam int unsigned Beats = beats(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  logic [2:0]      valid_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            last_d, out_last_q;

  for (genvar j = 0; j < PIXELS_PER_BEAT; j++) begin : g_lane
    ssim_lane #(
      .C1(C1),
      .C2(C2)
    ) u_lane (
      .clk_i    (clk),
      .areset_i (areset),
      .stall_i  (stall),
      .mu_x_i   (in_mu_x[j*MU_W +: MU_W]),
      .mu_y_i   (in_mu_y[j*MU_W +: MU_W]),
      .sig_x2_i (in_sig_x2[j*SIG_W +: SIG_W]),
      .sig_y2_i (in_sig_y2[j*SIG_W +: SIG_W]),
      .sig_xy_i (in_sig_xy[j*SIG_W +: SIG_W]),
      .num_o    (out_num[j*PROD_W +: PROD_W]),
      .den_o    (out_den[j*PROD_W +: PROD_W])
    );
  end

  // Counter tracks beats already emitted this frame; advances as a valid beat enters the output
  always_comb begin
    cnt_d  = cnt_q;
    last_d = valid_q[1] && (cnt_q == LastCnt);
    if (valid_q[1]) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
    end
  end

  // Valid pipe, frame counter and registered out_last, all frozen by stall
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      valid_q    <= '0;
      cnt_q      <= '0;
      out_last_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= {valid_q[1:0], in_valid};
      cnt_q      <= cnt_d;
      out_last_q <= last_d;
    end
  end

  assign out_valid = valid_q[2];
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_ssim_num_den.sv
// Self-checking bench for ssim_num_den with a small 8x8 frame (4 beats of 16 lanes).
module tb_ssim_num_den;

  localparam int unsigned P      = 16;
  localparam int unsigned DIM    = 8;
  localparam int unsigned NBEATS = 4;   // 8*8 pixels / 16 lanes
  localparam int unsigned NW     = 36 * P;

  typedef struct packed {
    logic          v;
    logic          last;
    logic [NW-1:0] num;
    logic [NW-1:0] den;
  } rec_t;

  logic            clk = 1'b0;
  logic            areset, stall, in_valid;
  logic [8*P-1:0]  in_mu_x, in_mu_y;
  logic [16*P-1:0] in_sig_x2, in_sig_y2, in_sig_xy;
  logic [NW-1:0]   out_num, out_den;
  logic            out_valid, out_last;

  int checks = 0;
  int errors = 0;
  rec_t q[$];
  int unsigned outcnt;
  int unsigned vidx;
  int unsigned last_mask;
  logic [NW-1:0] frozen_num, frozen_den;

  always #5 clk = ~clk;

  ssim_num_den #(
    .PIXELS_PER_BEAT(P),
    .IMAGE_DIM(DIM)
  ) dut (
    .clk       (clk),
    .areset    (areset),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_mu_x   (in_mu_x),
    .in_mu_y   (in_mu_y),
    .in_sig_x2 (in_sig_x2),
    .in_sig_y2 (in_sig_y2),
    .in_sig_xy (in_sig_xy),
    .out_num   (out_num),
    .out_den   (out_den),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

  // SSIM terms straight from the formulas, using wide signed integers
  function automatic rec_t model_beat();
    rec_t r;
    longint mx, my, sx, sy, sxy, a, b, e, f;
    r.v    = in_valid;
    r.last = 1'b0;
    r.num  = '0;
    r.den  = '0;
    for (int j = 0; j < P; j++) begin
      mx  = longint'(in_mu_x[j*8 +: 8]);
      my  = longint'(in_mu_y[j*8 +: 8]);
      sx  = longint'(in_sig_x2[j*16 +: 16]);
      sy  = longint'(in_sig_y2[j*16 +: 16]);
      sxy = longint'($signed(in_sig_xy[j*16 +: 16]));
      a = 2 * mx * my + 7;
      b = 2 * sxy + 59;
      if (b < 0) b = 0;
      e = mx * mx + my * my + 7;
      f = sx + sy + 59;
      r.num[j*36 +: 36] = 36'(a * b);
      r.den[j*36 +: 36] = 36'(e * f);
    end
    return r;
  endfunction

  task automatic model_reset();
    rec_t z;
    z = '0;
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(z);
    outcnt = 0;
  endtask

  task automatic check_out();
    rec_t e;
    e = q[0];
    checks++;
    assert (out_valid === e.v) else begin
      errors++; $error("FAIL out_valid: got %b want %b", out_valid, e.v);
    end
    checks++;
    assert (out_last === e.last) else begin
      errors++; $error("FAIL out_last: got %b want %b", out_last, e.last);
    end
    checks++;
    assert (out_num === e.num) else begin
      errors++; $error("FAIL out_num: got %h want %h", out_num, e.num);
    end
    checks++;
    assert (out_den === e.den) else begin
      errors++; $error("FAIL out_den: got %h want %h", out_den, e.den);
    end
  endtask

  // Advance one clock, step the reference pipeline (3 non-stalled cycles deep), then compare
  task automatic tick();
    rec_t cur;
    @(posedge clk);
    if (areset) begin
      model_reset();
    end else if (!stall) begin
      q.push_back(model_beat());
      void'(q.pop_front());
      cur = q[0];
      if (cur.v) begin
        cur.last = (outcnt == NBEATS - 1);
        outcnt   = (outcnt + 1) % NBEATS;
      end
      q[0] = cur;
    end
    #1;
    check_out();
    if (!stall && !areset && out_valid) begin
      vidx++;
      if (out_last) last_mask |= (32'd1 << vidx);
    end
  endtask

  task automatic set_all(input logic [7:0] mx, input logic [7:0] my, input logic [15:0] sx2,
                         input logic [15:0] sy2, input logic [15:0] sxy);
    in_mu_x   = {P{mx}};
    in_mu_y   = {P{my}};
    in_sig_x2 = {P{sx2}};
    in_sig_y2 = {P{sy2}};
    in_sig_xy = {P{sxy}};
  endtask

  task automatic set_rand();
    for (int j = 0; j < P; j++) begin
      in_mu_x[j*8 +: 8]     = 8'($urandom);
      in_mu_y[j*8 +: 8]     = 8'($urandom);
      in_sig_x2[j*16 +: 16] = 16'($urandom);
      in_sig_y2[j*16 +: 16] = 16'($urandom);
      in_sig_xy[j*16 +: 16] = 16'($urandom);
    end
  endtask

  // Single valid beat followed by idle cycles until it reaches the output
  task automatic pulse();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_const(input string tag, input longint n, input longint d);
    logic [35:0] n36, d36;
    n36 = 36'(n);
    d36 = 36'(d);
    checks++;
    assert (out_valid === 1'b1) else begin
      errors++; $error("FAIL %s valid: got %b want 1", tag, out_valid);
    end
    checks++;
    assert (out_num === {P{n36}}) else begin
      errors++; $error("FAIL %s num: got %h want %h", tag, out_num[35:0], n36);
    end
    checks++;
    assert (out_den === {P{d36}}) else begin
      errors++; $error("FAIL %s den: got %h want %h", tag, out_den[35:0], d36);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert (out_num === '0 && out_den === '0 && out_valid === 1'b0 && out_last === 1'b0)
    else begin
      errors++;
      $error("FAIL %s: got v=%b l=%b num0=%h den0=%h want all 0", tag, out_valid, out_last,
             out_num[35:0], out_den[35:0]);
    end
  endtask

  task automatic check_mask(input string tag, input int unsigned want);
    checks++;
    assert (last_mask === want) else begin
      errors++; $error("FAIL %s: got last mask %h want %h", tag, last_mask, want);
    end
  endtask

  initial begin
    areset   = 1'b1;
    stall    = 1'b0;
    in_valid = 1'b0;
    set_all(8'd0, 8'd0, 16'd0, 16'd0, 16'd0);
    model_reset();
    vidx      = 0;
    last_mask = 0;
    tick();
    tick();
    check_zero("reset");
    areset = 1'b0;

    // Zero statistics: both products collapse to C1*C2
    pulse();
    check_const("zero_stats", 64'd413, 64'd413);
    tick();

    // Negative correlation clamps the contrast term to zero
    set_all(8'd100, 8'd100, 16'd50, 16'd50, 16'hFF9C);
    pulse();
    check_const("neg_corr", 64'd0, 64'd3181113);

    // Largest inputs must not wrap
    set_all(8'd255, 8'd255, 16'hFFFF, 16'hFFFF, 16'h7FFF);
    pulse();
    check_const("max_vals", 64'd130057 * 64'd65593, 64'd130057 * 64'd131129);

    // Stall mid-stream: outputs frozen, stream continues intact afterwards
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_rand();
      tick();
    end
    stall      = 1'b1;
    frozen_num = out_num;
    frozen_den = out_den;
    for (int i = 0; i < 5; i++) begin
      set_rand();
      in_valid = 1'($urandom);
      tick();
    end
    checks++;
    assert (out_num === frozen_num && out_den === frozen_den) else begin
      errors++; $error("FAIL stall_freeze: got %h want %h", out_num[35:0], frozen_num[35:0]);
    end
    stall    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_rand();
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Random traffic with random gaps and stalls
    for (int i = 0; i < 200; i++) begin
      set_rand();
      in_valid = 1'($urandom);
      stall    = ($urandom_range(0, 3) == 0);
      tick();
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Frame boundary: two frames of 4 beats with gaps
    areset = 1'b1;
    tick();
    areset    = 1'b0;
    vidx      = 0;
    last_mask = 0;
    for (int i = 0; i < 8; i++) begin
      set_rand();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < (i % 3); k++) tick();
    end
    for (int i = 0; i < 4; i++) tick();
    check_mask("frame_last", (32'd1 << 4) | (32'd1 << 8));

    // Asynchronous reset mid-frame while a beat is in flight, with stall also high
    vidx      = 0;
    last_mask = 0;
    for (int i = 0; i < 2; i++) begin
      set_rand();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    set_rand();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    areset = 1'b1;
    stall  = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    tick();
    check_zero("reset_over_stall");
    areset    = 1'b0;
    stall     = 1'b0;
    vidx      = 0;
    last_mask = 0;
    for (int i = 0; i < 4; i++) begin
      set_rand();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
    check_mask("post_reset_last", 32'd1 << 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
